slsr_sched: RTL and testbench

Round-robin scheduler and sequencer for the 8-bit shift-left/shift-right register (`slsr`). Two requesters each submit a parallel word and a shift direction. The block grants one requester at a time and serially shifts the word into the register through its `sl`/`sr`/`din` pins. It then reads back `Q`, checks it against the submitted word, and reports completion. It sits between the requesting logic and a single `slsr` instance that shares the same `clk` and `reset`.

---
 rtl/slsr_sched.sv | 134 +++++++++++++
 tb/tb_slsr_sched.sv | 282 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/slsr_sched.sv
// slsr_sched: round-robin scheduler that loads an 8-bit shift register serially
// Ports: clk/reset, two valid/ready request ports with data+dir,
//    sl/sr/din to the shift register, q readback, busy/done status, err_count.
module slsr_sched #(
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             req0_valid,
   output logic             req0_ready,
   input  logic [WIDTH-1:0] req0_data,
   input  logic             req0_dir,
   input  logic             req1_valid,
   output logic             req1_ready,
   input  logic [WIDTH-1:0] req1_data,
   input  logic             req1_dir,
   output logic             sl,
   output logic             sr,
   output logic             din,
   input  logic [WIDTH-1:0] q,
   output logic             busy,
   output logic             done,
   output logic             done_id,
   output logic             done_ok,
   output logic [7:0]       err_count
);

   localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
   localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);

   typedef enum logic [1:0] {
      IDLE,
      SHIFT,
      CHECK
   } state_t;

   state_t           state;
   state_t           state_nxt;
   logic [CW-1:0]    cnt;
   logic [CW-1:0]    bit_idx;
   logic             last;
   logic             cap_id;
   logic             cap_dir;
   logic [WIDTH-1:0] cap_data;
   logic             match;

   // dir=1 loads MSB first through sl, dir=0 loads LSB first through sr
   assign bit_idx = cap_dir ? (CNT_LAST - cnt) : cnt;
   assign match   = (q == cap_data);

   always_comb begin
      state_nxt  = state;
      req0_ready = 1'b0;
      req1_ready = 1'b0;
      sl         = 1'b0;
      sr         = 1'b0;
      din        = 1'b0;
      busy       = 1'b0;
      done       = 1'b0;
      done_id    = 1'b0;
      done_ok    = 1'b0;
      unique case (state)
         IDLE: begin
            // on a tie the requester that was not served last wins
            req0_ready = req0_valid && (!req1_valid || last);
            req1_ready = req1_valid && (!req0_valid || !last);
            if (req0_ready || req1_ready) begin
               state_nxt = SHIFT;
            end
         end
         SHIFT: begin
            busy = 1'b1;
            sl   = cap_dir;
            sr   = !cap_dir;
            din  = cap_data[bit_idx];
            if (cnt == CNT_LAST) begin
               state_nxt = CHECK;
            end
         end
         CHECK: begin
            busy      = 1'b1;
            done      = 1'b1;
            done_id   = cap_id;
            done_ok   = match;
            state_nxt = IDLE;
         end
         default: begin
            state_nxt = IDLE;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state     <= IDLE;
         cnt       <= '0;
         last      <= 1'b1;
         cap_id    <= 1'b0;
         cap_dir   <= 1'b0;
         cap_data  <= '0;
         err_count <= 8'd0;
      end else begin
         state <= state_nxt;
         unique case (state)
            IDLE: begin
               if (req0_ready) begin
                  cap_id   <= 1'b0;
                  cap_dir  <= req0_dir;
                  cap_data <= req0_data;
                  last     <= 1'b0;
                  cnt      <= '0;
               end else if (req1_ready) begin
                  cap_id   <= 1'b1;
                  cap_dir  <= req1_dir;
                  cap_data <= req1_data;
                  last     <= 1'b1;
                  cnt      <= '0;
               end
            end
            SHIFT: begin
               cnt <= cnt + CW'(1);
            end
            CHECK: begin
               if (!match && err_count != 8'hFF) begin
                  err_count <= err_count + 8'd1;
               end
            end
            default: begin
            end
         endcase
      end
   end

endmodule

// File: tb/tb_slsr_sched.sv
// tb_slsr_sched: directed bench for slsr_sched with a behavioural slsr model
// No ports; prints one TB_RESULT summary line.
module tb_slsr_sched;

   logic       clk = 1'b0;
   logic       reset = 1'b1;
   logic       req0_valid = 1'b0;
   logic       req0_ready;
   logic [7:0] req0_data = 8'h00;
   logic       req0_dir = 1'b0;
   logic       req1_valid = 1'b0;
   logic       req1_ready;
   logic [7:0] req1_data = 8'h00;
   logic       req1_dir = 1'b0;
   logic       sl;
   logic       sr;
   logic       din;
   logic [7:0] q;
   logic       busy;
   logic       done;
   logic       done_id;
   logic       done_ok;
   logic [7:0] err_count;

   logic [7:0] slsr_q;
   logic       stuck = 1'b0;
   logic       prev_done;

   int checks = 0;
   int failures = 0;

   slsr_sched #(.WIDTH(8)) dut (
      .clk        (clk),
      .reset      (reset),
      .req0_valid (req0_valid),
      .req0_ready (req0_ready),
      .req0_data  (req0_data),
      .req0_dir   (req0_dir),
      .req1_valid (req1_valid),
      .req1_ready (req1_ready),
      .req1_data  (req1_data),
      .req1_dir   (req1_dir),
      .sl         (sl),
      .sr         (sr),
      .din        (din),
      .q          (q),
      .busy       (busy),
      .done       (done),
      .done_id    (done_id),
      .done_ok    (done_ok),
      .err_count  (err_count)
   );

   always #5 clk = ~clk;

   // the shift register being loaded
   always_ff @(posedge clk) begin
      if (reset) slsr_q <= 8'h00;
      else if (sr) slsr_q <= {din, slsr_q[7:1]};
      else if (sl) slsr_q <= {slsr_q[6:0], din};
   end

   assign q = stuck ? 8'h00 : slsr_q;

   task automatic chk(input string tag, input logic [31:0] got,
                      input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   always @(negedge clk) begin
      if (!reset) begin
         chk("sl_sr_excl", {31'b0, sl & sr}, 32'd0);
         chk("ready_busy", {31'b0, (req0_ready | req1_ready) & busy}, 32'd0);
         chk("done_twice", {31'b0, done & prev_done}, 32'd0);
      end
      prev_done <= reset ? 1'b0 : done;
   end

   task automatic xfer(input bit who, input bit dr, input logic [7:0] dat,
                       input bit detail, output logic [7:0] seq,
                       output int lat, output bit ok, output bit id,
                       output logic [7:0] qv);
      seq = 8'h00;
      lat = 0;
      ok  = 1'b0;
      id  = 1'b0;
      qv  = 8'h00;
      if (who) begin
         req1_valid = 1'b1;
         req1_dir   = dr;
         req1_data  = dat;
      end else begin
         req0_valid = 1'b1;
         req0_dir   = dr;
         req0_data  = dat;
      end
      #1;
      if (detail) chk("ready_grant", {31'b0, who ? req1_ready : req0_ready}, 32'd1);
      tick;
      req0_valid = 1'b0;
      req1_valid = 1'b0;
      req0_data  = ~dat;
      req1_data  = ~dat;
      req0_dir   = ~dr;
      req1_dir   = ~dr;
      lat = 1;
      while (!done && lat < 20) begin
         if (detail && lat <= 8) begin
            chk("shift_sr", {31'b0, sr}, {31'b0, !dr});
            chk("shift_sl", {31'b0, sl}, {31'b0, dr});
            seq[8-lat] = din;
         end
         tick;
         lat++;
      end
      chk("done_seen", {31'b0, done}, 32'd1);
      ok = done_ok;
      id = done_id;
      qv = q;
      tick;
   endtask

   logic [7:0] seq;
   logic [7:0] qv;
   int         lat;
   bit         ok;
   bit         id;
   logic [3:0] gseq;
   logic [3:0] dseq;
   int         r0cnt;
   int         r1cnt;
   int         ng;
   int         nd;
   int         bad;
   int         ndone;

   initial begin
      tick;
      tick;
      chk("rst_sl", {31'b0, sl}, 32'd0);
      chk("rst_sr", {31'b0, sr}, 32'd0);
      chk("rst_din", {31'b0, din}, 32'd0);
      chk("rst_busy", {31'b0, busy}, 32'd0);
      chk("rst_done", {31'b0, done}, 32'd0);
      chk("rst_done_id", {31'b0, done_id}, 32'd0);
      chk("rst_done_ok", {31'b0, done_ok}, 32'd0);
      chk("rst_err", {24'b0, err_count}, 32'd0);
      chk("rst_q", {24'b0, q}, 32'd0);
      reset = 1'b0;
      req0_valid = 1'b1;
      req1_valid = 1'b1;
      #1;
      chk("tie_r0", {31'b0, req0_ready}, 32'd1);
      chk("tie_r1", {31'b0, req1_ready}, 32'd0);
      req0_valid = 1'b0;
      req1_valid = 1'b0;
      #1;
      chk("idle_r0", {31'b0, req0_ready}, 32'd0);
      chk("idle_r1", {31'b0, req1_ready}, 32'd0);
      tick;

      xfer(1'b0, 1'b0, 8'hA5, 1'b1, seq, lat, ok, id, qv);
      chk("t1_din_seq", {24'b0, seq}, 32'h000000A5);
      chk("t1_latency", lat, 32'd9);
      chk("t1_q", {24'b0, qv}, 32'h000000A5);
      chk("t1_id", {31'b0, id}, 32'd0);
      chk("t1_ok", {31'b0, ok}, 32'd1);

      xfer(1'b1, 1'b1, 8'h3C, 1'b1, seq, lat, ok, id, qv);
      chk("t2_din_seq", {24'b0, seq}, 32'h0000003C);
      chk("t2_latency", lat, 32'd9);
      chk("t2_q", {24'b0, qv}, 32'h0000003C);
      chk("t2_id", {31'b0, id}, 32'd1);
      chk("t2_ok", {31'b0, ok}, 32'd1);
      chk("t2_err", {24'b0, err_count}, 32'd0);

      reset = 1'b1;
      tick;
      reset = 1'b0;
      req0_data  = 8'h01;
      req0_dir   = 1'b0;
      req1_data  = 8'h80;
      req1_dir   = 1'b1;
      req0_valid = 1'b1;
      req1_valid = 1'b1;
      gseq = 4'h0;
      dseq = 4'h0;
      r0cnt = 0;
      r1cnt = 0;
      ng = 0;
      nd = 0;
      bad = 0;
      for (int i = 0; i < 40; i++) begin
         #1;
         if (req0_ready) begin
            r0cnt++;
            ng++;
            gseq = {gseq[2:0], 1'b0};
         end
         if (req1_ready) begin
            r1cnt++;
            ng++;
            gseq = {gseq[2:0], 1'b1};
         end
         if (done) begin
            nd++;
            dseq = {dseq[2:0], done_id};
            if (!done_ok) bad++;
         end
         tick;
      end
      req0_valid = 1'b0;
      req1_valid = 1'b0;
      chk("rr_grant_cnt", ng, 32'd4);
      chk("rr_grant_seq", {28'b0, gseq}, 32'b0101);
      chk("rr_r0_pulses", r0cnt, 32'd2);
      chk("rr_r1_pulses", r1cnt, 32'd2);
      chk("rr_done_cnt", nd, 32'd4);
      chk("rr_done_seq", {28'b0, dseq}, 32'b0101);
      chk("rr_bad_ok", bad, 32'd0);
      tick;

      stuck = 1'b1;
      xfer(1'b0, 1'b0, 8'hFF, 1'b1, seq, lat, ok, id, qv);
      chk("st_ok", {31'b0, ok}, 32'd0);
      chk("st_err1", {24'b0, err_count}, 32'd1);
      for (int i = 2; i <= 254; i++) begin
         xfer(i[0], 1'b0, 8'hFF, 1'b0, seq, lat, ok, id, qv);
      end
      chk("st_err254", {24'b0, err_count}, 32'd254);
      xfer(1'b1, 1'b1, 8'hFF, 1'b0, seq, lat, ok, id, qv);
      chk("st_err255", {24'b0, err_count}, 32'd255);
      for (int i = 256; i <= 300; i++) begin
         xfer(i[0], 1'b0, 8'hFF, 1'b0, seq, lat, ok, id, qv);
      end
      chk("st_err_sat", {24'b0, err_count}, 32'd255);
      stuck = 1'b0;

      req0_valid = 1'b1;
      req0_dir   = 1'b0;
      req0_data  = 8'h5A;
      tick;
      req0_valid = 1'b0;
      tick;
      tick;
      tick;
      chk("mid_busy_pre", {31'b0, busy}, 32'd1);
      chk("mid_sr_pre", {31'b0, sr}, 32'd1);
      reset = 1'b1;
      tick;
      reset = 1'b0;
      chk("mid_busy", {31'b0, busy}, 32'd0);
      chk("mid_sl", {31'b0, sl}, 32'd0);
      chk("mid_sr", {31'b0, sr}, 32'd0);
      chk("mid_q", {24'b0, q}, 32'd0);
      chk("mid_err", {24'b0, err_count}, 32'd0);
      ndone = 0;
      for (int i = 0; i < 15; i++) begin
         if (done) ndone++;
         tick;
      end
      chk("mid_no_done", ndone, 32'd0);
      xfer(1'b1, 1'b1, 8'hC3, 1'b1, seq, lat, ok, id, qv);
      chk("post_seq", {24'b0, seq}, 32'h000000C3);
      chk("post_q", {24'b0, qv}, 32'h000000C3);
      chk("post_id", {31'b0, id}, 32'd1);
      chk("post_ok", {31'b0, ok}, 32'd1);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
